// File: rtl/switch_pkt_arbiter.sv
// switch_pkt_arbiter: round-robin, packet-granular output-port arbiter.
// Picks one of N_PORTS input buffers, locks onto it until the packet tail
// passes, and presents the chosen flit in a single registered output stage.
//
// Output handshake: out_valid=1 means out_flit/out_last/out_select hold a flit
// that has not been taken yet. The flit is consumed on a rising CLK edge where
// out_valid && out_ready. While out_valid && !out_ready the stage is frozen.
// The register may load a new flit whenever it is empty or being consumed
// (load_en). pop[i] is the matching dequeue strobe to input i: it is high in
// exactly the cycle its flit is loaded, and never while RST is high.
module switch_pkt_arbiter #(
    parameter int N_PORTS = 4,
    parameter int FLIT_W  = 32,
    parameter int BURST   = 1,
    parameter int SEL_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_PORTS-1:0]        bid,
    input  logic [N_PORTS*FLIT_W-1:0] rdata,
    input  logic [N_PORTS-1:0]        last,
    output logic [N_PORTS-1:0]        pop,
    output logic [FLIT_W-1:0]         out_flit,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_select,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      locked
);

    // Burst counter only needs to reach BURST-1.
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   win;
    logic [SEL_W-1:0]   scan;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sel_valid;
    logic               load_en;
    logic               load;

    assign load_en = !out_valid || out_ready;
    assign load    = load_en && sel_valid && !RST;

    // Winner selection: locked owner, burst continuation, or round-robin scan from ptr+1.
    always_comb begin
        win       = ptr;
        scan      = ptr;
        sel_valid = 1'b0;
        cnt_nxt   = cnt;
        if (state == LOCKED) begin
            sel_valid = bid[ptr];
        end else if (bid[ptr] && (int'(cnt) < BURST - 1)) begin
            sel_valid = 1'b1;
            cnt_nxt   = cnt + 1'b1;
        end else begin
            cnt_nxt = '0;
            // Visits ptr+1 .. ptr (ptr last), wrapping explicitly at N_PORTS-1.
            for (int k = 0; k < N_PORTS; k++) begin
                scan = (scan == SEL_W'(N_PORTS - 1)) ? '0 : scan + 1'b1;
                if (!sel_valid && bid[scan]) begin
                    sel_valid = 1'b1;
                    win       = scan;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a non-tail head locks, the owner's tail unlocks.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load && !last[win]) state_nxt = LOCKED;
            LOCKED:  if (load && last[win])  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: dequeue strobe for the loaded input and the lock indicator.
    always_comb begin
        pop = '0;
        if (load) begin
            pop[win] = 1'b1;
        end
        locked = (state == LOCKED);
    end

    // Output register, round-robin pointer and burst counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_flit   <= '0;
            out_last   <= 1'b0;
            out_select <= '0;
            out_valid  <= 1'b0;
            ptr        <= SEL_W'(N_PORTS - 1);
            cnt        <= '0;
        end else if (load) begin
            out_flit   <= rdata[win*FLIT_W +: FLIT_W];
            out_last   <= last[win];
            out_select <= win;
            out_valid  <= 1'b1;
            ptr        <= win;
            cnt        <= cnt_nxt;
        end else if (load_en) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_pkt_arbiter.sv
// Bench for switch_pkt_arbiter: directed vector table plus randomized
// traffic compared against a behavioural model. Instance a uses BURST=1,
// instance b uses BURST=2; both see the same inputs.
module tb_switch_pkt_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    // ---------------- clock / reset / shared inputs ----------------
    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   bid = '0;
    logic [N-1:0]   last = '0;
    logic [N*W-1:0] rdata = '0;
    logic           out_ready = 1'b1;

    always #5 CLK = ~CLK;

    logic [N-1:0]  a_pop, b_pop;
    logic [W-1:0]  a_flit, b_flit;
    logic          a_last, b_last, a_valid, b_valid, a_locked, b_locked;
    logic [SW-1:0] a_sel, b_sel;

    switch_pkt_arbiter #(.N_PORTS(N), .FLIT_W(W), .BURST(1)) dut_a (
        .CLK(CLK), .RST(RST), .bid(bid), .rdata(rdata), .last(last),
        .pop(a_pop), .out_flit(a_flit), .out_last(a_last), .out_select(a_sel),
        .out_valid(a_valid), .out_ready(out_ready), .locked(a_locked)
    );

    switch_pkt_arbiter #(.N_PORTS(N), .FLIT_W(W), .BURST(2)) dut_b (
        .CLK(CLK), .RST(RST), .bid(bid), .rdata(rdata), .last(last),
        .pop(b_pop), .out_flit(b_flit), .out_last(b_last), .out_select(b_sel),
        .out_valid(b_valid), .out_ready(out_ready), .locked(b_locked)
    );

    // ---------------- check bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] port_flit(input int i);
        logic [W-1:0] f;
        f = (i == 0) ? 32'hDEADBEEF : 32'hC0DE0000 + 32'(i);
        return f;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] bid;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] pop;
        logic       chk_regs;
        logic       valid;
        logic [1:0] sel;
        logic       lst;
        logic       lck;
        logic       use_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [3:0] l,
                                input logic rd, input logic [3:0] p, input logic c,
                                input logic vl, input logic [1:0] s, input logic ls,
                                input logic lk, input logic ub);
        vec_t v;
        v.rst = r; v.bid = b; v.last = l; v.rdy = rd; v.pop = p; v.chk_regs = c;
        v.valid = vl; v.sel = s; v.lst = ls; v.lck = lk; v.use_b = ub;
        return v;
    endfunction

    task automatic fill_vectors();
        // All four ports bid single-flit packets: 0,1,2,3,0 rotation.
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0, 1, 0, 0));
        // Port 2 three-flit packet while port 0 keeps bidding.
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 1, 4'b0100, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0001, 1, 4'b0100, 1, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0101, 4'b0101, 1, 4'b0100, 1, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 2, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0, 1, 0, 0));
        // Locked on port 1, its bid drops for two cycles while port 3 waits.
        vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 4'b0000, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 4'b0000, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1010, 4'b1010, 1, 4'b0010, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 3, 1, 0, 0));
        // Backpressure: DEADBEEF from port 0 held for four cycles.
        vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 3, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 4'b0011, 4'b0011, 0, 4'b0000, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0010, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 1, 1, 0, 0));
        // BURST=2 instance after reset: 0,0,1,1,0,0.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0010, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0010, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0011, 4'b0011, 1, 4'b0001, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 1, 0, 1));
        // Reset while locked on port 3, then port 0 wins against port 3.
        vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 3, 0, 1, 0));
        vecs.push_back(mk(1, 4'b1000, 4'b0000, 1, 4'b0000, 1, 1, 3, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0001, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 1, 0, 0));
    endtask

    // ---------------- behavioural reference model ----------------
    // Per instance: turn holder, packets used in its turn, lock owner flag,
    // and the flit currently expected in the output stage.
    bit           rnd_on = 1'b0;
    int           burst_of[2] = '{1, 2};
    int           m_ptr[2];
    int           m_cnt[2];
    bit           m_lock[2];
    bit           m_valid[2];
    bit           m_last[2];
    int           m_sel[2];
    logic [W-1:0] m_flit[2];

    task automatic model_reset(input int k);
        m_ptr[k] = N - 1; m_cnt[k] = 0; m_lock[k] = 0;
        m_valid[k] = 0; m_last[k] = 0; m_sel[k] = 0; m_flit[k] = '0;
    endtask

    // Port that gets the output register this cycle, or -1.
    function automatic int pick(input int k);
        if (RST) return -1;
        if (m_valid[k] && !out_ready) return -1;
        if (m_lock[k]) return bid[m_ptr[k]] ? m_ptr[k] : -1;
        if (bid[m_ptr[k]] && (m_cnt[k] + 1 < burst_of[k])) return m_ptr[k];
        for (int j = 1; j <= N; j++)
            if (bid[(m_ptr[k] + j) % N]) return (m_ptr[k] + j) % N;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int w;
        bit cont;
        if (RST) begin
            model_reset(k);
            return;
        end
        w    = pick(k);
        cont = !m_lock[k] && bid[m_ptr[k]] && (m_cnt[k] + 1 < burst_of[k]);
        if (w >= 0) begin
            m_flit[k]  = rdata[w*W +: W];
            m_last[k]  = last[w];
            m_sel[k]   = w;
            m_valid[k] = 1;
            if (m_lock[k]) begin
                if (last[w]) m_lock[k] = 0;
            end else begin
                m_cnt[k]  = cont ? m_cnt[k] + 1 : 0;
                m_lock[k] = !last[w];
            end
            m_ptr[k] = w;
        end else if (!m_valid[k] || out_ready) begin
            m_valid[k] = 0;
        end
    endtask

    always @(posedge CLK) begin
        if (rnd_on) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge CLK) begin
        if (rnd_on) begin
            for (int k = 0; k < 2; k++) begin
                int         w;
                logic [3:0] ep;
                w  = pick(k);
                ep = (w >= 0) ? 4'(1 << w) : 4'b0000;
                chk($sformatf("rnd%0d pop", k),    32'(k ? b_pop : a_pop), 32'(ep));
                chk($sformatf("rnd%0d valid", k),  32'(k ? b_valid : a_valid), 32'(m_valid[k]));
                chk($sformatf("rnd%0d locked", k), 32'(k ? b_locked : a_locked), 32'(m_lock[k]));
                chk($sformatf("rnd%0d sel", k),    32'(k ? b_sel : a_sel), 32'(m_sel[k]));
                chk($sformatf("rnd%0d last", k),   32'(k ? b_last : a_last), 32'(m_last[k]));
                chk($sformatf("rnd%0d flit", k),   k ? b_flit : a_flit, m_flit[k]);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t         v;
        logic [3:0]   p;
        logic         vl, ls, lk;
        logic [1:0]   s;
        logic [W-1:0] f;

        for (int i = 0; i < N; i++) rdata[i*W +: W] = port_flit(i);
        fill_vectors();

        // Reset values on both instances.
        RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst a valid", 32'(a_valid), 0);
        chk("rst a flit", a_flit, 0);
        chk("rst a last", 32'(a_last), 0);
        chk("rst a sel", 32'(a_sel), 0);
        chk("rst a locked", 32'(a_locked), 0);
        chk("rst a pop", 32'(a_pop), 0);
        chk("rst b valid", 32'(b_valid), 0);
        chk("rst b locked", 32'(b_locked), 0);
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            RST = v.rst; bid = v.bid; last = v.last; out_ready = v.rdy;
            @(negedge CLK);
            if (v.use_b) begin
                p = b_pop; vl = b_valid; s = b_sel; ls = b_last; lk = b_locked; f = b_flit;
            end else begin
                p = a_pop; vl = a_valid; s = a_sel; ls = a_last; lk = a_locked; f = a_flit;
            end
            chk($sformatf("vec%0d pop", i), 32'(p), 32'(v.pop));
            if (v.chk_regs) begin
                chk($sformatf("vec%0d valid", i),  32'(vl), 32'(v.valid));
                chk($sformatf("vec%0d sel", i),    32'(s),  32'(v.sel));
                chk($sformatf("vec%0d last", i),   32'(ls), 32'(v.lst));
                chk($sformatf("vec%0d locked", i), 32'(lk), 32'(v.lck));
                if (v.valid) chk($sformatf("vec%0d flit", i), f, port_flit(int'(v.sel)));
            end
            @(posedge CLK); #1;
        end

        // Randomized traffic against the model.
        RST = 1'b1; bid = '0; last = '0; out_ready = 1'b1;
        @(posedge CLK); #1;
        model_reset(0);
        model_reset(1);
        rnd_on = 1'b1;
        repeat (3000) begin
            RST       = ($urandom_range(0, 199) == 0);
            bid       = 4'($urandom_range(0, 15));
            last      = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) rdata[i*W +: W] = $urandom;
            @(posedge CLK); #1;
        end
        rnd_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
